// File: rtl/cdc_hs_tx_pkg.sv
// Shared definitions for the 2-phase req/ack handshake pair (tx here, rx in the far domain).
// Holds the FSM state encoding and the default word width used by both ends.
// No logic; types and constants only.
package cdc_hs_tx_pkg;

  // One 64b/66b block per transferred word.
  localparam int CDC_HS_WIDTH = 66;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } hs_state_e;

endpackage : cdc_hs_tx_pkg

// File: rtl/sync_2xdff.sv
// Two-flop synchronizer for quasi-static or toggle signals entering the clk domain.
// Latency: 2 clk cycles from input change to q.
// Backpressure: none; samples every cycle.
// Ports: clk, rst (sync active-high), d (async input), q (synchronized output).
module sync_2xdff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule : sync_2xdff

// File: rtl/cdc_hs_tx.sv
// Source-domain side of a 2-phase toggle req/ack handshake carrying PCS control/status words.
// Latency: accept -> req_tgl/tx_data next cycle; ack edge at A -> done/in_ready at A+3.
// Backpressure: in_ready low from accept until the matching ack toggle returns.
// Ports:
//   clk, rst            source clock, synchronous active-high reset
//   in_valid/in_data    upstream word, accepted when in_valid & in_ready
//   in_ready            registered; high only in IDLE
//   tx_data, req_tgl    held word and request toggle to the far domain
//   ack_tgl_in          asynchronous ack toggle from the far domain
//   done                one-cycle pulse when the outstanding word is acknowledged
//   err_clr             clears sticky flags (a same-cycle set wins)
//   timeout_err         sticky: ACK_TIMEOUT WAIT cycles without a matching ack
//   proto_err           sticky: ack toggled with no request outstanding
module cdc_hs_tx
  import cdc_hs_tx_pkg::*;
#(
  parameter int WIDTH       = CDC_HS_WIDTH,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] tx_data,
  output logic             req_tgl,
  input  logic             ack_tgl_in,
  output logic             done,
  input  logic             err_clr,
  output logic             timeout_err,
  output logic             proto_err
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_TIMEOUT);
  // The flag must be visible after exactly ACK_TIMEOUT unacknowledged WAIT
  // cycles, so the set condition fires one count early.
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(ACK_TIMEOUT - 1);

  hs_state_e        state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             req_tgl_q, req_tgl_d;
  logic [WIDTH-1:0] tx_data_q, tx_data_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_err_q, timeout_err_d;
  logic             proto_err_q, proto_err_d;

  logic ack_sync;
  logic ack_match;
  logic timeout_set;
  logic proto_set;

  // The far end is reset together with this block and drives ack low while
  // held, so the synchronizer flushes to 0 without needing its own reset.
  sync_2xdff #(
    .WIDTH(1)
  ) u_ack_sync (
    .clk(clk),
    .rst(1'b0),
    .d  (ack_tgl_in),
    .q  (ack_sync)
  );

  // With toggle signalling, "acked" means both toggles have the same phase.
  assign ack_match = (ack_sync == req_tgl_q);

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    req_tgl_d   = req_tgl_q;
    tx_data_d   = tx_data_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    timeout_set = 1'b0;
    proto_set   = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        // Nothing is outstanding, so any phase difference is a stray ack.
        proto_set  = ~ack_match;
        if (in_valid && in_ready_q) begin
          tx_data_d  = in_data;
          req_tgl_d  = ~req_tgl_q;
          state_d    = WAIT;
          in_ready_d = 1'b0;
          cnt_d      = '0;
        end
      end
      WAIT: begin
        in_ready_d = 1'b0;
        if (ack_match) begin
          state_d    = IDLE;
          in_ready_d = 1'b1;
          done_d     = 1'b1;
        end else begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          // Keep waiting after a timeout: aborting would desynchronize the toggles.
          if (cnt_q >= CNT_PRE) begin
            timeout_set = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    timeout_err_d = timeout_set | (timeout_err_q & ~err_clr);
    proto_err_d   = proto_set   | (proto_err_q   & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      in_ready_q    <= 1'b0;
      req_tgl_q     <= 1'b0;
      tx_data_q     <= '0;
      done_q        <= 1'b0;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      req_tgl_q     <= req_tgl_d;
      tx_data_q     <= tx_data_d;
      done_q        <= done_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
      proto_err_q   <= proto_err_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign tx_data     = tx_data_q;
  assign req_tgl     = req_tgl_q;
  assign done        = done_q;
  assign timeout_err = timeout_err_q;
  assign proto_err   = proto_err_q;

endmodule : cdc_hs_tx
